// File: rtl/chipper_pkg.sv
// Shared definitions for the CHIPPER bufferless deflection router:
// port indices and flit field layout helpers.
package chipper_pkg;

  localparam logic [2:0] PORT_E     = 3'd0;
  localparam logic [2:0] PORT_W     = 3'd1;
  localparam logic [2:0] PORT_N     = 3'd2;
  localparam logic [2:0] PORT_S     = 3'd3;
  localparam logic [2:0] PORT_LOCAL = 3'd4;

  // Flit layout MSB to LSB: {valid, dst_x, dst_y, hops, data}
  function automatic int flit_width(input int coord_w, input int hop_w, input int data_w);
    return 1 + 2 * coord_w + hop_w + data_w;
  endfunction

  function automatic int hops_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int dst_y_lsb(input int hop_w, input int data_w);
    return data_w + hop_w;
  endfunction

  function automatic int dst_x_lsb(input int coord_w, input int hop_w, input int data_w);
    return data_w + hop_w + coord_w;
  endfunction

  function automatic int valid_bit(input int coord_w, input int hop_w, input int data_w);
    return data_w + hop_w + 2 * coord_w;
  endfunction

endpackage

// File: rtl/chipper_route_calc.sv
// Dimension-ordered (X then Y) productive port for one flit.
module chipper_route_calc
  import chipper_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
) (
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  output logic [2:0]         port
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

  always_comb begin
    port = PORT_LOCAL;
    if (dst_x > MY_X)      port = PORT_E;
    else if (dst_x < MY_X) port = PORT_W;
    else if (dst_y > MY_Y) port = PORT_N;
    else if (dst_y < MY_Y) port = PORT_S;
  end

endmodule

// File: rtl/chipper_router.sv
// Bufferless deflection router: oldest-first ranking, single eject, local
// inject into a spare output, one register stage on every output.
module chipper_router
  import chipper_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 2,
  parameter int HOP_W   = 4,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   east_in,
  input  logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   west_in,
  input  logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   north_in,
  input  logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   south_in,
  input  logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   inject_flit,
  input  logic                                            inject_valid,
  output logic                                            inject_ready,
  output logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   east_out,
  output logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   west_out,
  output logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   north_out,
  output logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   south_out,
  output logic [flit_width(COORD_W, HOP_W, DATA_W)-1:0]   eject_flit,
  output logic                                            eject_valid
);

  localparam int FLIT_W   = flit_width(COORD_W, HOP_W, DATA_W);
  localparam int HOPS_LSB = hops_lsb(DATA_W);
  localparam int DY_LSB   = dst_y_lsb(HOP_W, DATA_W);
  localparam int DX_LSB   = dst_x_lsb(COORD_W, HOP_W, DATA_W);
  localparam int VLD_BIT  = valid_bit(COORD_W, HOP_W, DATA_W);
  localparam logic [HOP_W-1:0] HOP_MAX = '1;

  logic [FLIT_W-1:0] in_flit [5];
  logic [2:0]        prod_port [5];
  int                rank [4];
  logic [FLIT_W-1:0] out_nxt [4];
  logic [FLIT_W-1:0] out_q [4];
  logic [FLIT_W-1:0] eject_nxt;
  logic              eject_vld_nxt;
  logic              unused_inject_bits;

  // Slot 4 is the inject flit, normalised to valid with a fresh hop count
  assign in_flit[0] = east_in;
  assign in_flit[1] = west_in;
  assign in_flit[2] = north_in;
  assign in_flit[3] = south_in;
  assign in_flit[4] = {1'b1, inject_flit[DX_LSB +: COORD_W], inject_flit[DY_LSB +: COORD_W],
                       {HOP_W{1'b0}}, inject_flit[DATA_W-1:0]};
  assign unused_inject_bits = ^{inject_flit[VLD_BIT], inject_flit[HOPS_LSB +: HOP_W]};

  for (genvar g = 0; g < 5; g++) begin : g_route
    chipper_route_calc #(
      .COORD_W (COORD_W),
      .X_ID    (X_ID),
      .Y_ID    (Y_ID)
    ) u_calc (
      .dst_x (in_flit[g][DX_LSB +: COORD_W]),
      .dst_y (in_flit[g][DY_LSB +: COORD_W]),
      .port  (prod_port[g])
    );
  end

  function automatic logic [FLIT_W-1:0] bump(input logic [FLIT_W-1:0] f);
    bump = f;
    if (f[HOPS_LSB +: HOP_W] != HOP_MAX)
      bump[HOPS_LSB +: HOP_W] = f[HOPS_LSB +: HOP_W] + HOP_W'(1);
  endfunction

  // Productive port if still free, else the lowest-index free output
  function automatic logic [1:0] pick_out(input logic [2:0] want, input logic [3:0] busy);
    pick_out = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (!busy[k]) pick_out = 2'(k);
    if (want < PORT_LOCAL && !busy[want[1:0]]) pick_out = want[1:0];
  endfunction

  // Rank = number of valid flits that are older, or equally old on a lower port
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rank[i] = 0;
      for (int j = 0; j < 4; j++)
        if (j != i && in_flit[j][VLD_BIT] &&
            ((in_flit[j][HOPS_LSB +: HOP_W] > in_flit[i][HOPS_LSB +: HOP_W]) ||
             (in_flit[j][HOPS_LSB +: HOP_W] == in_flit[i][HOPS_LSB +: HOP_W] && j < i)))
          rank[i] = rank[i] + 1;
    end
  end

  always_comb begin
    logic [3:0] busy;
    logic [1:0] sel;
    busy          = 4'b0;
    sel           = 2'd0;
    eject_nxt     = '0;
    eject_vld_nxt = 1'b0;
    inject_ready  = 1'b0;
    for (int k = 0; k < 4; k++) out_nxt[k] = '0;

    for (int pos = 0; pos < 4; pos++) begin
      for (int i = 0; i < 4; i++) begin
        if (in_flit[i][VLD_BIT] && rank[i] == pos) begin
          if (prod_port[i] == PORT_LOCAL && !eject_vld_nxt) begin
            eject_nxt     = in_flit[i];
            eject_vld_nxt = 1'b1;
          end else begin
            sel          = pick_out(prod_port[i], busy);
            out_nxt[sel] = bump(in_flit[i]);
            busy[sel]    = 1'b1;
          end
        end
      end
    end

    // Inject only into a spare output slot, after all neighbour flits
    inject_ready = rst_n && inject_valid && (busy != 4'b1111);
    if (inject_ready) begin
      if (prod_port[4] == PORT_LOCAL && !eject_vld_nxt) begin
        eject_nxt     = in_flit[4];
        eject_vld_nxt = 1'b1;
      end else begin
        sel          = pick_out(prod_port[4], busy);
        out_nxt[sel] = bump(in_flit[4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) out_q[k] <= '0;
      eject_flit  <= '0;
      eject_valid <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) out_q[k] <= out_nxt[k];
      eject_flit  <= eject_nxt;
      eject_valid <= eject_vld_nxt;
    end
  end

  assign east_out  = out_q[0];
  assign west_out  = out_q[1];
  assign north_out = out_q[2];
  assign south_out = out_q[3];

endmodule

// File: tb/tb_chipper_router.sv
// Scoreboard bench for chipper_router at mesh position (1,1): stimulus pushes
// expected outputs, a monitor pops and compares them one cycle later.
module tb_chipper_router;

  localparam int FW = 17;
  localparam logic [FW-1:0] Z = '0;

  typedef struct {
    string         name;
    logic [FW-1:0] e, w, n, s, ej;
    logic          ejv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] east_in, west_in, north_in, south_in, inject_flit;
  logic          inject_valid, inject_ready;
  logic [FW-1:0] east_out, west_out, north_out, south_out, eject_flit;
  logic          eject_valid;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  chipper_router #(
    .DATA_W(8), .COORD_W(2), .HOP_W(4), .X_ID(1), .Y_ID(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .east_in(east_in), .west_in(west_in), .north_in(north_in), .south_in(south_in),
    .inject_flit(inject_flit), .inject_valid(inject_valid), .inject_ready(inject_ready),
    .east_out(east_out), .west_out(west_out), .north_out(north_out), .south_out(south_out),
    .eject_flit(eject_flit), .eject_valid(eject_valid)
  );

  function automatic logic [FW-1:0] mk(input logic v, input logic [1:0] x, input logic [1:0] y,
                                       input logic [3:0] h, input logic [7:0] d);
    return {v, x, y, h, d};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expected result
  task automatic apply_stimulus(input string name, input logic rst,
                                input logic [FW-1:0] e, w, n, s, inj, input logic injv,
                                input logic exp_ready,
                                input logic [FW-1:0] xe, xw, xn, xs, xej, input logic xejv);
    exp_t x;
    rst_n = rst; east_in = e; west_in = w; north_in = n; south_in = s;
    inject_flit = inj; inject_valid = injv;
    x.name = name; x.e = xe; x.w = xw; x.n = xn; x.s = xs; x.ej = xej; x.ejv = xejv;
    exp_q.push_back(x);
    #1;
    check_output({name, "_ready"}, 128'(inject_ready), 128'(exp_ready));
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_output(x.name,
                     128'({east_out, west_out, north_out, south_out, eject_flit, eject_valid}),
                     128'({x.e, x.w, x.n, x.s, x.ej, x.ejv}));
      end
    end
  end

  initial begin : stimulus
    apply_stimulus("reset_hold", 1'b0, mk(1,2,1,3,8'hA5), mk(1,0,1,3,8'hA6), mk(1,1,2,3,8'hA7),
                   mk(1,1,0,3,8'hA8), mk(1,2,1,0,8'h99), 1'b1, 1'b0, Z, Z, Z, Z, Z, 1'b0);
    apply_stimulus("single", 1'b1, Z, mk(1,2,1,3,8'hA5), Z, Z, Z, 1'b0, 1'b0,
                   mk(1,2,1,4,8'hA5), Z, Z, Z, Z, 1'b0);
    apply_stimulus("conflict", 1'b1, mk(1,2,1,2,8'h11), mk(1,2,1,5,8'h22), Z, Z, Z, 1'b0, 1'b0,
                   mk(1,2,1,6,8'h22), mk(1,2,1,3,8'h11), Z, Z, Z, 1'b0);
    apply_stimulus("eject", 1'b1, Z, Z, mk(1,1,1,1,8'h33), mk(1,1,1,1,8'h44), Z, 1'b0, 1'b0,
                   mk(1,1,1,2,8'h44), Z, Z, Z, mk(1,1,1,1,8'h33), 1'b1);
    apply_stimulus("inj_blocked", 1'b1, mk(1,2,1,0,8'h01), mk(1,0,1,0,8'h02), mk(1,1,2,0,8'h03),
                   mk(1,1,0,0,8'h04), mk(0,2,1,7,8'h99), 1'b1, 1'b0,
                   mk(1,2,1,1,8'h01), mk(1,0,1,1,8'h02), mk(1,1,2,1,8'h03), mk(1,1,0,1,8'h04),
                   Z, 1'b0);
    apply_stimulus("inj_accept", 1'b1, mk(1,2,1,0,8'h01), mk(1,0,1,0,8'h02), mk(1,1,2,0,8'h03),
                   Z, mk(0,2,1,7,8'h99), 1'b1, 1'b1,
                   mk(1,2,1,1,8'h01), mk(1,0,1,1,8'h02), mk(1,1,2,1,8'h03), mk(1,2,1,1,8'h99),
                   Z, 1'b0);
    apply_stimulus("saturate", 1'b1, Z, Z, mk(1,1,2,15,8'h55), Z, Z, 1'b0, 1'b0,
                   Z, Z, mk(1,1,2,15,8'h55), Z, Z, 1'b0);
    apply_stimulus("inj_eject", 1'b1, Z, Z, Z, Z, mk(0,1,1,5,8'h66), 1'b1, 1'b1,
                   Z, Z, Z, Z, mk(1,1,1,0,8'h66), 1'b1);
    apply_stimulus("inj_deflect", 1'b1, Z, Z, mk(1,1,1,3,8'h77), Z, mk(1,1,1,0,8'h88), 1'b1, 1'b1,
                   mk(1,1,1,1,8'h88), Z, Z, Z, mk(1,1,1,3,8'h77), 1'b1);
    apply_stimulus("invalid_ignored", 1'b1, mk(0,3,3,9,8'hFF), mk(1,1,2,2,8'h12), Z,
                   mk(1,1,2,2,8'h13), Z, 1'b0, 1'b0,
                   mk(1,1,2,3,8'h13), Z, mk(1,1,2,3,8'h12), Z, Z, 1'b0);
    apply_stimulus("tie_index", 1'b1, mk(1,2,1,7,8'h21), Z, Z, mk(1,2,1,7,8'h24), Z, 1'b0, 1'b0,
                   mk(1,2,1,8,8'h21), mk(1,2,1,8,8'h24), Z, Z, Z, 1'b0);
    apply_stimulus("hops_first", 1'b1, mk(1,0,1,1,8'h31), Z, mk(1,0,1,4,8'h32), Z, Z, 1'b0, 1'b0,
                   mk(1,0,1,2,8'h31), mk(1,0,1,5,8'h32), Z, Z, Z, 1'b0);
    apply_stimulus("reset_again", 1'b0, mk(1,2,1,3,8'hB1), mk(1,0,1,3,8'hB2), mk(1,1,1,3,8'hB3),
                   mk(1,1,0,3,8'hB4), mk(1,1,1,0,8'hB5), 1'b1, 1'b0, Z, Z, Z, Z, Z, 1'b0);
    apply_stimulus("post_reset", 1'b1, mk(1,1,0,0,8'h41), Z, Z, Z, Z, 1'b0, 1'b0,
                   Z, Z, Z, mk(1,1,0,1,8'h41), Z, 1'b0);
    apply_stimulus("idle", 1'b1, Z, Z, Z, Z, Z, 1'b0, 1'b0, Z, Z, Z, Z, Z, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check_output("drain", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
